// File: rtl/regfile_rename_mp.sv
// Multi-port architectural register file with per-register busy bit and producing-ROB tag.
// Serves combinational operand reads with commit bypass and intra-group rename forwarding.
module regfile_rename_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int REG_W    = 5,
    parameter int TAG_W    = 4,
    parameter int DISPATCH = 2,
    parameter int COMMIT   = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [DISPATCH-1:0]             dispatch_valid,
    input  logic [DISPATCH*REG_W-1:0]       dispatch_rd,
    input  logic [DISPATCH*TAG_W-1:0]       dispatch_tag,
    input  logic [COMMIT-1:0]               commit_valid,
    input  logic [COMMIT*REG_W-1:0]         commit_rd,
    input  logic [COMMIT*TAG_W-1:0]         commit_tag,
    input  logic [COMMIT*XLEN-1:0]          commit_data,
    input  logic                            flush_input,
    input  logic [2*DISPATCH*REG_W-1:0]     rd_addr,
    output logic [2*DISPATCH*XLEN-1:0]      rd_data,
    output logic [2*DISPATCH-1:0]           rd_busy,
    output logic [2*DISPATCH*TAG_W-1:0]     rd_tag,
    output logic [REG_W:0]                  num_busy
);
    localparam int NRD = 2 * DISPATCH;

    // No valid/ready: every enabled slot is consumed in the cycle it is presented.
    logic [XLEN-1:0]  data_q [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [NREG-1:0]  busy_q;
    logic [XLEN-1:0]  data_n [NREG];
    logic [TAG_W-1:0] tag_n  [NREG];
    logic [NREG-1:0]  busy_n;
    logic [REG_W:0]   count_n;

    logic [REG_W-1:0] c_rd   [COMMIT];
    logic [TAG_W-1:0] c_tag  [COMMIT];
    logic [XLEN-1:0]  c_data [COMMIT];
    logic [REG_W-1:0] d_rd   [DISPATCH];
    logic [TAG_W-1:0] d_tag  [DISPATCH];
    logic [REG_W-1:0] r_addr [NRD];
    logic [XLEN-1:0]  r_data [NRD];
    logic             r_busy [NRD];
    logic [TAG_W-1:0] r_tag  [NRD];

    always_comb begin : unpack
        for (int c = 0; c < COMMIT; c++) begin
            c_rd[c]   = commit_rd[c*REG_W +: REG_W];
            c_tag[c]  = commit_tag[c*TAG_W +: TAG_W];
            c_data[c] = commit_data[c*XLEN +: XLEN];
        end
        for (int d = 0; d < DISPATCH; d++) begin
            d_rd[d]  = dispatch_rd[d*REG_W +: REG_W];
            d_tag[d] = dispatch_tag[d*TAG_W +: TAG_W];
        end
        for (int j = 0; j < NRD; j++) begin
            r_addr[j] = rd_addr[j*REG_W +: REG_W];
        end
    end

    // Loop order gives the younger slot the final word on a shared rd.
    always_comb begin : next_state
        data_n = data_q;
        tag_n  = tag_q;
        busy_n = busy_q;
        for (int c = 0; c < COMMIT; c++) begin
            if (commit_valid[c] && c_rd[c] != '0) begin
                data_n[c_rd[c]] = c_data[c];
                if (busy_q[c_rd[c]] && c_tag[c] == tag_q[c_rd[c]]) begin
                    busy_n[c_rd[c]] = 1'b0;
                end
            end
        end
        for (int d = 0; d < DISPATCH; d++) begin
            if (!flush_input && dispatch_valid[d] && d_rd[d] != '0) begin
                busy_n[d_rd[d]] = 1'b1;
                tag_n[d_rd[d]]  = d_tag[d];
            end
        end
        if (flush_input) begin
            busy_n = '0;
        end
        busy_n[0] = 1'b0;
        count_n = '0;
        for (int r = 1; r < NREG; r++) begin
            count_n = count_n + {{REG_W{1'b0}}, busy_n[r]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q   <= '0;
            num_busy <= '0;
        end else begin
            data_q   <= data_n;
            tag_q    <= tag_n;
            busy_q   <= busy_n;
            num_busy <= count_n;
        end
    end

    // Forwarding from older slots is applied after the bypass so it wins.
    always_comb begin : read_ports
        for (int j = 0; j < NRD; j++) begin
            r_data[j] = data_q[r_addr[j]];
            r_busy[j] = busy_q[r_addr[j]];
            r_tag[j]  = tag_q[r_addr[j]];
            for (int c = 0; c < COMMIT; c++) begin
                if (commit_valid[c] && r_addr[j] != '0 && c_rd[c] == r_addr[j]) begin
                    r_data[j] = c_data[c];
                    if (c_tag[c] == tag_q[r_addr[j]]) begin
                        r_busy[j] = 1'b0;
                    end
                end
            end
            for (int i = 0; i < DISPATCH; i++) begin
                if (i < j / 2 && dispatch_valid[i] && r_addr[j] != '0 && d_rd[i] == r_addr[j]) begin
                    r_busy[j] = 1'b1;
                    r_tag[j]  = d_tag[i];
                end
            end
        end
    end

    always_comb begin : pack
        rd_data = '0;
        rd_busy = '0;
        rd_tag  = '0;
        for (int j = 0; j < NRD; j++) begin
            rd_data[j*XLEN +: XLEN]   = r_data[j];
            rd_busy[j]                = r_busy[j];
            rd_tag[j*TAG_W +: TAG_W]  = r_tag[j];
        end
    end
endmodule

// File: tb/tb_regfile_rename_mp.sv
// Self-checking bench for regfile_rename_mp: vector table plus hand-written multi-cycle sequences.
module tb_regfile_rename_mp;
    localparam int XLEN = 32;
    localparam int REG_W = 5;
    localparam int TAG_W = 4;
    localparam int DISPATCH = 2;
    localparam int COMMIT = 2;

    logic                        clk_in;
    logic                        rst_in;
    logic [DISPATCH-1:0]         dispatch_valid;
    logic [DISPATCH*REG_W-1:0]   dispatch_rd;
    logic [DISPATCH*TAG_W-1:0]   dispatch_tag;
    logic [COMMIT-1:0]           commit_valid;
    logic [COMMIT*REG_W-1:0]     commit_rd;
    logic [COMMIT*TAG_W-1:0]     commit_tag;
    logic [COMMIT*XLEN-1:0]      commit_data;
    logic                        flush_input;
    logic [2*DISPATCH*REG_W-1:0] rd_addr;
    logic [2*DISPATCH*XLEN-1:0]  rd_data;
    logic [2*DISPATCH-1:0]       rd_busy;
    logic [2*DISPATCH*TAG_W-1:0] rd_tag;
    logic [REG_W:0]              num_busy;

    int errors = 0;
    int checks = 0;

    // {tag_care, port, busy, tag, data}
    logic [39:0] exp_q[$];

    typedef struct {
        logic        dv;
        logic [4:0]  drd;
        logic [3:0]  dtag;
        logic        cv;
        logic [4:0]  crd;
        logic [3:0]  ctag;
        logic [31:0] cdata;
        logic [4:0]  raddr;
        logic [31:0] exp_d;
        logic        exp_b;
        logic [3:0]  exp_t;
        logic [5:0]  exp_num;
    } vec_t;

    vec_t vecs[12];

    regfile_rename_mp #(
        .XLEN(XLEN), .NREG(32), .REG_W(REG_W), .TAG_W(TAG_W),
        .DISPATCH(DISPATCH), .COMMIT(COMMIT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .dispatch_valid(dispatch_valid), .dispatch_rd(dispatch_rd), .dispatch_tag(dispatch_tag),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .commit_data(commit_data), .flush_input(flush_input),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .num_busy(num_busy)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic dv, input logic [4:0] drd, input logic [3:0] dtag,
                                input logic cv, input logic [4:0] crd, input logic [3:0] ctag,
                                input logic [31:0] cdata, input logic [4:0] raddr,
                                input logic [31:0] ed, input logic eb, input logic [3:0] et,
                                input logic [5:0] en);
        vec_t v;
        v.dv = dv; v.drd = drd; v.dtag = dtag;
        v.cv = cv; v.crd = crd; v.ctag = ctag; v.cdata = cdata;
        v.raddr = raddr; v.exp_d = ed; v.exp_b = eb; v.exp_t = et; v.exp_num = en;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = '0; dispatch_rd = '0; dispatch_tag = '0;
        commit_valid = '0; commit_rd = '0; commit_tag = '0; commit_data = '0;
        flush_input = 1'b0;
        rd_addr = '0;
    endtask

    task automatic disp(input int s, input logic [4:0] rd, input logic [3:0] tag);
        dispatch_valid[s] = 1'b1;
        dispatch_rd[s*REG_W +: REG_W] = rd;
        dispatch_tag[s*TAG_W +: TAG_W] = tag;
    endtask

    task automatic commit(input int s, input logic [4:0] rd, input logic [3:0] tag,
                          input logic [31:0] data);
        commit_valid[s] = 1'b1;
        commit_rd[s*REG_W +: REG_W] = rd;
        commit_tag[s*TAG_W +: TAG_W] = tag;
        commit_data[s*XLEN +: XLEN] = data;
    endtask

    task automatic read(input int p, input logic [4:0] addr);
        rd_addr[p*REG_W +: REG_W] = addr;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_read(input logic [1:0] p, input logic [31:0] d, input logic b,
                               input logic [3:0] t, input logic tc);
        exp_q.push_back({tc, p, b, t, d});
    endtask

    task automatic check_reads(input string name);
        logic [39:0] e;
        logic [38:0] a;
        int p;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = int'(e[38:37]);
            a = {e[38:37], rd_busy[p], rd_tag[p*TAG_W +: TAG_W], rd_data[p*XLEN +: XLEN]};
            if (!e[39]) begin
                a[35:32] = e[35:32];
            end
            check($sformatf("%s port%0d", name, p), {25'h0, a}, {25'h0, e[38:0]});
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 5, 3, 0, 0, 0, 32'h0,        5, 32'h0,        0, 0, 1);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        5, 32'h0,        1, 3, 1);
        vecs[2]  = mk(0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 5, 32'hDEADBEEF, 0, 3, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        5, 32'hDEADBEEF, 0, 3, 0);
        vecs[4]  = mk(1, 7, 2, 0, 0, 0, 32'h0,        7, 32'h0,        0, 0, 1);
        vecs[5]  = mk(1, 7, 9, 0, 0, 0, 32'h0,        7, 32'h0,        1, 2, 1);
        vecs[6]  = mk(0, 0, 0, 1, 7, 2, 32'h11,       7, 32'h11,       1, 9, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        7, 32'h11,       1, 9, 1);
        vecs[8]  = mk(1, 0, 5, 1, 0, 0, 32'hFFFFFFFF, 0, 32'h0,        0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1);
        vecs[10] = mk(0, 0, 0, 1, 7, 9, 32'h22,       7, 32'h22,       0, 9, 0);
        vecs[11] = mk(0, 0, 0, 1, 9, 4, 32'h33,       9, 32'h33,       0, 0, 0);

        // Clock/reset
        rst_in = 1'b0;
        idle();
        read(0, 5); read(3, 31);
        #3;
        expect_read(0, 32'h0, 0, 0, 1);
        expect_read(3, 32'h0, 0, 0, 1);
        check_reads("reset");
        check("reset num_busy", num_busy, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        step();
        check("post-reset num_busy", num_busy, 0);

        // Vector table on slot-0 port 0
        for (int k = 0; k < 12; k++) begin
            idle();
            if (vecs[k].dv) disp(0, vecs[k].drd, vecs[k].dtag);
            if (vecs[k].cv) commit(0, vecs[k].crd, vecs[k].ctag, vecs[k].cdata);
            read(0, vecs[k].raddr);
            expect_read(0, vecs[k].exp_d, vecs[k].exp_b, vecs[k].exp_t,
                        vecs[k].exp_b | (vecs[k].raddr == 5'd0));
            #2;
            check_reads($sformatf("vec%0d", k));
            step();
            check($sformatf("vec%0d num_busy", k), num_busy, vecs[k].exp_num);
        end

        // Same-cycle conflicts on x4
        idle(); disp(0, 4, 12);
        step();
        check("conflict setup num_busy", num_busy, 1);
        idle();
        disp(0, 4, 1); disp(1, 4, 6); commit(0, 4, 12, 32'h44);
        read(0, 4); read(1, 4); read(2, 4); read(3, 5);
        expect_read(0, 32'h44, 0, 12, 0);
        expect_read(1, 32'h44, 0, 12, 0);
        expect_read(2, 32'h44, 1, 1, 1);
        expect_read(3, 32'hDEADBEEF, 0, 3, 0);
        #2; check_reads("conflict");
        step();
        check("conflict num_busy", num_busy, 1);
        idle();
        commit(0, 4, 1, 32'h55); commit(1, 4, 2, 32'h66);
        disp(0, 0, 7); disp(1, 11, 3);
        read(0, 4); read(2, 0); read(3, 11);
        expect_read(0, 32'h66, 1, 6, 1);
        expect_read(2, 32'h0, 0, 0, 1);
        expect_read(3, 32'h0, 0, 0, 0);
        #2; check_reads("stale pair");
        step();
        check("stale pair num_busy", num_busy, 2);
        idle(); read(0, 4); read(1, 11);
        expect_read(0, 32'h66, 1, 6, 1);
        expect_read(1, 32'h0, 1, 3, 1);
        #2; check_reads("after conflict");
        step();
        check("after conflict num_busy", num_busy, 2);

        // Flush with five busy registers
        idle(); disp(0, 12, 4); disp(1, 13, 5);
        step();
        check("flush setup a num_busy", num_busy, 4);
        idle(); disp(0, 14, 8);
        step();
        check("flush setup b num_busy", num_busy, 5);
        idle(); flush_input = 1'b1;
        commit(0, 3, 0, 32'h42); disp(0, 8, 2);
        read(0, 3); read(2, 8);
        expect_read(0, 32'h42, 0, 0, 0);
        expect_read(2, 32'h0, 1, 2, 1);
        #2; check_reads("flush cycle");
        step();
        check("flush num_busy", num_busy, 0);
        idle(); read(0, 3); read(1, 8); read(2, 14);
        expect_read(0, 32'h42, 0, 0, 0);
        expect_read(1, 32'h0, 0, 0, 0);
        expect_read(2, 32'h0, 0, 0, 0);
        #2; check_reads("after flush");
        step();
        check("after flush num_busy", num_busy, 0);

        // Asynchronous reset mid-operation
        idle(); disp(0, 20, 1); disp(1, 21, 2);
        step();
        check("pre-reset num_busy", num_busy, 2);
        idle(); read(0, 20); read(1, 5);
        expect_read(0, 32'h0, 1, 1, 1);
        expect_read(1, 32'hDEADBEEF, 0, 3, 0);
        #2; check_reads("pre-reset");
        #1 rst_in = 1'b0;
        #1;
        expect_read(0, 32'h0, 0, 0, 1);
        expect_read(1, 32'h0, 0, 0, 1);
        check_reads("async reset");
        check("async reset num_busy", num_busy, 0);
        disp(0, 22, 1);
        step(); step();
        check("held reset num_busy", num_busy, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(); read(0, 20); read(1, 22);
        step();
        expect_read(0, 32'h0, 0, 0, 1);
        expect_read(1, 32'h0, 0, 0, 1);
        check_reads("after release");
        check("after release num_busy", num_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
